cache_nway: RTL and testbench

Parametrised N-way set-associative, write-back, write-allocate cache between the CPU's 32-bit word port and 256-bit line-granular physical memory. It is the successor of the current single-configuration cache, with configurable set count and associativity, tree-PLRU replacement, and invalid-way-first victim selection. It contains its own controller FSM, tag/valid/dirty/PLRU arrays, data array and word/line bus adaptation.

---
 rtl/cache_nway_pkg.sv | 35 +++
 rtl/cache_plru.sv | 34 +++
 rtl/cache_nway.sv | 224 ++++++++++++++++++++++
 tb/tb_cache_nway.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_nway_pkg.sv
// Shared types and helpers for the N-way set-associative cache.
package cache_nway_pkg;

  localparam int LINE_BITS = 256;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    CHECK     = 3'd1,
    WRITEBACK = 3'd2,
    FILL      = 3'd3,
    RESP      = 3'd4
  } state_t;

  // Walk the PLRU tree from the root; bit value 1 steers toward the upper child.
  // The root splits on way bit 0, the next level on way bit 1, and so on.
  function automatic logic [2:0] plru_victim(input logic [6:0] bits, input int ways);
    logic [2:0] node;
    logic [2:0] way;
    logic       dir;
    node = 3'd0;
    way  = 3'd0;
    dir  = 1'b0;
    for (int l = 0; l < 3; l++) begin
      if ((32'd1 << l) < 32'(ways)) begin
        dir    = bits[node];
        way[l] = dir;
        node   = {node[1:0], 1'b0} + 3'd1 + {2'b00, dir};
      end else begin
        dir = 1'b0;
      end
    end
    return way;
  endfunction

endpackage

// File: rtl/cache_plru.sv
// Tree-PLRU helper: next PLRU bits after touching a way, and the current victim.
module cache_plru
  import cache_nway_pkg::*;
#(
  parameter int num_ways = 4,
  localparam int way_bits = $clog2(num_ways)
) (
  input  logic [num_ways-2:0] bits,
  input  logic [way_bits-1:0] access_way,
  output logic [num_ways-2:0] new_bits,
  output logic [way_bits-1:0] victim
);

  logic [6:0] bits_pad_s;
  logic [6:0] upd_pad_s;
  logic [2:0] node_s;
  logic [2:0] vic_pad_s;

  // Point every node on the accessed way's path away from that way.
  always_comb begin
    bits_pad_s                 = 7'd0;
    bits_pad_s[num_ways-2:0]   = bits;
    upd_pad_s                  = bits_pad_s;
    node_s                     = 3'd0;
    for (int l = 0; l < way_bits; l++) begin
      upd_pad_s[node_s] = ~access_way[l];
      node_s            = {node_s[1:0], 1'b0} + 3'd1 + {2'b00, access_way[l]};
    end
    vic_pad_s = plru_victim(bits_pad_s, num_ways);
    new_bits  = upd_pad_s[num_ways-2:0];
    victim    = vic_pad_s[way_bits-1:0];
  end

endmodule

// File: rtl/cache_nway.sv
// N-way set-associative write-back/write-allocate cache with tree-PLRU replacement.
// Optional performance counters are enabled by defining CACHE_NWAY_PERF_EN.
module cache_nway
  import cache_nway_pkg::*;
#(
  parameter int s_offset = 5,
  parameter int s_index  = 3,
  parameter int num_ways = 4,
  parameter int s_tag    = 32 - s_offset - s_index
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [31:0]          mem_address,
  output logic [31:0]          mem_rdata,
  input  logic [31:0]          mem_wdata,
  input  logic                 mem_read,
  input  logic                 mem_write,
  input  logic [3:0]           mem_byte_enable,
  output logic                 mem_resp,
  output logic [31:0]          pmem_address,
  input  logic [LINE_BITS-1:0] pmem_rdata,
  output logic [LINE_BITS-1:0] pmem_wdata,
  output logic                 pmem_read,
  output logic                 pmem_write,
  input  logic                 pmem_resp
`ifdef CACHE_NWAY_PERF_EN
  ,
  output logic [31:0]          perf_hits,
  output logic [31:0]          perf_misses,
  output logic [31:0]          perf_writebacks
`endif
);

  localparam int sets     = 2 ** s_index;
  localparam int way_bits = $clog2(num_ways);

  state_t                state_r, next_s;
  logic [31:0]           addr_r;
  logic [31:0]           wdata_r;
  logic [3:0]            be_r;
  logic                  write_r;
  logic [way_bits-1:0]   victim_r;

  logic [s_tag-1:0]      tag_r   [num_ways][sets];
  logic [LINE_BITS-1:0]  data_r  [num_ways][sets];
  logic [num_ways-1:0]   valid_r [sets];
  logic [num_ways-1:0]   dirty_r [sets];
  logic [num_ways-2:0]   plru_r  [sets];

  logic [s_tag-1:0]      tag_s;
  logic [s_index-1:0]    index_s;
  logic [2:0]            word_s;
  logic [num_ways-1:0]   hit_vec_s;
  logic [num_ways-1:0]   inv_vec_s;
  logic                  hit_s;
  logic [way_bits-1:0]   hit_way_s;
  logic [way_bits-1:0]   inv_way_s;
  logic [way_bits-1:0]   plru_vic_s;
  logic [way_bits-1:0]   victim_s;
  logic                  victim_dirty_s;
  logic [num_ways-2:0]   plru_upd_s;
  logic [LINE_BITS-1:0]  hit_line_s;
  logic [31:0]           rd_word_s;
  logic [31:0]           merged_s;
  logic [LINE_BITS-1:0]  wr_line_s;

  assign tag_s     = addr_r[31 -: s_tag];
  assign index_s   = addr_r[s_offset +: s_index];
  assign word_s    = addr_r[4:2];
  assign inv_vec_s = ~valid_r[index_s];

  for (genvar w = 0; w < num_ways; w++) begin : g_cmp
    assign hit_vec_s[w] = valid_r[index_s][w] && (tag_r[w][index_s] == tag_s);
  end

  cache_plru #(.num_ways(num_ways)) u_plru (
    .bits       (plru_r[index_s]),
    .access_way (hit_way_s),
    .new_bits   (plru_upd_s),
    .victim     (plru_vic_s)
  );

  // Hit-way encode, lowest invalid way, victim choice and write-merge of the hit line.
  always_comb begin
    hit_way_s = '0;
    inv_way_s = '0;
    for (int w = num_ways - 1; w >= 0; w--) begin
      hit_way_s = hit_way_s | (hit_vec_s[w] ? way_bits'(w) : '0);
      inv_way_s = inv_vec_s[w] ? way_bits'(w) : inv_way_s;
    end
    hit_s          = |hit_vec_s;
    victim_s       = (|inv_vec_s) ? inv_way_s : plru_vic_s;
    victim_dirty_s = valid_r[index_s][victim_s] & dirty_r[index_s][victim_s];
    hit_line_s     = data_r[hit_way_s][index_s];
    rd_word_s      = hit_line_s[{word_s, 5'b00000} +: 32];
    for (int b = 0; b < 4; b++) begin
      merged_s[b*8 +: 8] = be_r[b] ? wdata_r[b*8 +: 8] : rd_word_s[b*8 +: 8];
    end
    wr_line_s                           = hit_line_s;
    wr_line_s[{word_s, 5'b00000} +: 32] = merged_s;
  end

  // Controller next-state decode.
  always_comb begin
    next_s = state_r;
    case (state_r)
      IDLE:      if (mem_read || mem_write) next_s = CHECK; else next_s = IDLE;
      CHECK:     if (hit_s) next_s = RESP;
                 else if (victim_dirty_s) next_s = WRITEBACK;
                 else next_s = FILL;
      WRITEBACK: if (pmem_resp) next_s = FILL; else next_s = WRITEBACK;
      FILL:      if (pmem_resp) next_s = CHECK; else next_s = FILL;
      RESP:      next_s = IDLE;
      default:   next_s = IDLE;
    endcase
  end

  // State register, request latch and registered bus outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= IDLE;
      addr_r       <= 32'd0;
      wdata_r      <= 32'd0;
      be_r         <= 4'd0;
      write_r      <= 1'b0;
      victim_r     <= '0;
      mem_resp     <= 1'b0;
      mem_rdata    <= 32'd0;
      pmem_read    <= 1'b0;
      pmem_write   <= 1'b0;
      pmem_address <= 32'd0;
      pmem_wdata   <= '0;
    end else begin
      state_r    <= next_s;
      mem_resp   <= (next_s == RESP);
      pmem_read  <= (next_s == FILL);
      pmem_write <= (next_s == WRITEBACK);
      if (state_r == IDLE && (mem_read || mem_write)) begin
        addr_r  <= mem_address;
        wdata_r <= mem_wdata;
        be_r    <= mem_byte_enable;
        write_r <= mem_write;
      end
      if (state_r == CHECK && hit_s && !write_r) mem_rdata <= rd_word_s;
      if (state_r == CHECK && !hit_s) victim_r <= victim_s;
      case (next_s)
        WRITEBACK: begin
          if (state_r == CHECK) begin
            pmem_address <= {tag_r[victim_s][index_s], index_s, {s_offset{1'b0}}};
            pmem_wdata   <= data_r[victim_s][index_s];
          end
        end
        FILL: begin
          pmem_address <= {tag_s, index_s, {s_offset{1'b0}}};
          pmem_wdata   <= '0;
        end
        default: begin
          pmem_address <= 32'd0;
          pmem_wdata   <= '0;
        end
      endcase
    end
  end

  // Valid/dirty/PLRU metadata; cleared by reset so an abandoned fill leaves nothing behind.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_r <= '{default: '0};
      dirty_r <= '{default: '0};
      plru_r  <= '{default: '0};
    end else begin
      case (state_r)
        CHECK: begin
          if (hit_s) begin
            plru_r[index_s] <= plru_upd_s;
            if (write_r && (be_r != 4'd0)) dirty_r[index_s][hit_way_s] <= 1'b1;
          end
        end
        WRITEBACK: if (pmem_resp) dirty_r[index_s][victim_r] <= 1'b0;
        FILL: begin
          if (pmem_resp) begin
            valid_r[index_s][victim_r] <= 1'b1;
            dirty_r[index_s][victim_r] <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // Line and tag storage; contents only matter once the way is valid.
  always_ff @(posedge clk) begin
    if (state_r == CHECK && hit_s && write_r) begin
      data_r[hit_way_s][index_s] <= wr_line_s;
    end else if (state_r == FILL && pmem_resp) begin
      data_r[victim_r][index_s] <= pmem_rdata;
      tag_r[victim_r][index_s]  <= tag_s;
    end
  end

`ifdef CACHE_NWAY_PERF_EN
  logic first_r;

  // Saturating event counters; hit/miss count only the first lookup of a request.
  always_ff @(posedge clk) begin
    if (rst) begin
      first_r         <= 1'b0;
      perf_hits       <= 32'd0;
      perf_misses     <= 32'd0;
      perf_writebacks <= 32'd0;
    end else begin
      if (state_r == IDLE && (mem_read || mem_write)) first_r <= 1'b1;
      else if (state_r == CHECK) first_r <= 1'b0;
      if (state_r == CHECK && first_r && hit_s && perf_hits != 32'hFFFF_FFFF)
        perf_hits <= perf_hits + 32'd1;
      if (state_r == CHECK && first_r && !hit_s && perf_misses != 32'hFFFF_FFFF)
        perf_misses <= perf_misses + 32'd1;
      if (state_r == WRITEBACK && pmem_resp && perf_writebacks != 32'hFFFF_FFFF)
        perf_writebacks <= perf_writebacks + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_cache_nway.sv
// Directed table-driven bench for cache_nway with a small line-memory model.
module tb_cache_nway;

  logic         clk;
  logic         rst;
  logic [31:0]  mem_address;
  logic [31:0]  mem_rdata;
  logic [31:0]  mem_wdata;
  logic         mem_read;
  logic         mem_write;
  logic [3:0]   mem_byte_enable;
  logic         mem_resp;
  logic [31:0]  pmem_address;
  logic [255:0] pmem_rdata;
  logic [255:0] pmem_wdata;
  logic         pmem_read;
  logic         pmem_write;
  logic         pmem_resp;
`ifdef CACHE_NWAY_PERF_EN
  logic [31:0]  perf_hits;
  logic [31:0]  perf_misses;
  logic [31:0]  perf_writebacks;
`endif

  cache_nway dut (
    .clk             (clk),
    .rst             (rst),
    .mem_address     (mem_address),
    .mem_rdata       (mem_rdata),
    .mem_wdata       (mem_wdata),
    .mem_read        (mem_read),
    .mem_write       (mem_write),
    .mem_byte_enable (mem_byte_enable),
    .mem_resp        (mem_resp),
    .pmem_address    (pmem_address),
    .pmem_rdata      (pmem_rdata),
    .pmem_wdata      (pmem_wdata),
    .pmem_read       (pmem_read),
    .pmem_write      (pmem_write),
    .pmem_resp       (pmem_resp)
`ifdef CACHE_NWAY_PERF_EN
    ,
    .perf_hits       (perf_hits),
    .perf_misses     (perf_misses),
    .perf_writebacks (perf_writebacks)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [255:0] mem_model [logic [31:0]];

  int           r_lat;
  logic [31:0]  r_rdata;
  int           r_fills;
  int           r_wbs;
  logic [31:0]  r_fill_addr;
  logic [31:0]  r_wb_addr;
  logic [255:0] r_wb_data;

  typedef struct {
    logic        wr;
    logic        rd;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        chk;
    logic [31:0] rdata;
    int          lat;
    int          fills;
    logic [31:0] fill_addr;
    int          wbs;
    logic [31:0] wb_addr;
  } vec_t;

  localparam int NV = 18;
  vec_t vecs [NV];

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Untouched lines read back as A5000000 + byte address of each word.
  function automatic logic [255:0] line_of(input logic [31:0] a);
    logic [255:0] l;
    if (mem_model.exists(a)) begin
      l = mem_model[a];
    end else begin
      for (int k = 0; k < 8; k++) l[k*32 +: 32] = 32'hA500_0000 + a + 32'(k * 4);
    end
    return l;
  endfunction

  task automatic do_req(input logic wr, input logic rd, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [3:0] be);
    int   c;
    int   wait_cnt;
    logic served_rd;
    bit   done;
    @(negedge clk);
    mem_write = wr; mem_read = rd; mem_address = addr; mem_wdata = wd; mem_byte_enable = be;
    r_lat = -1; r_rdata = 32'd0; r_fills = 0; r_wbs = 0;
    r_fill_addr = 32'd0; r_wb_addr = 32'd0; r_wb_data = '0;
    c = 0; wait_cnt = 0; served_rd = 1'b0; done = 1'b0;
    while (!done && c < 60) begin
      @(negedge clk);
      c++;
      check32("pmem_exclusive", {31'd0, pmem_read & pmem_write}, 32'd0);
      if (pmem_resp) begin
        pmem_resp = 1'b0;
        check32("strobe_drop", {31'd0, served_rd ? pmem_read : pmem_write}, 32'd0);
        wait_cnt = 0;
      end else if (pmem_read || pmem_write) begin
        if (wait_cnt == 0) begin
          if (pmem_write) begin
            r_wbs++; r_wb_addr = pmem_address; r_wb_data = pmem_wdata;
          end else begin
            r_fills++; r_fill_addr = pmem_address;
          end
        end
        wait_cnt++;
        if (wait_cnt == 2) begin
          served_rd = pmem_read;
          if (pmem_write) mem_model[pmem_address] = pmem_wdata;
          else pmem_rdata = line_of(pmem_address);
          pmem_resp = 1'b1;
        end
      end
      if (mem_resp) begin
        r_lat = c; r_rdata = mem_rdata; done = 1'b1;
        mem_read = 1'b0; mem_write = 1'b0;
      end
    end
    if (!done) begin
      n_checks++; n_fail++;
      $display("FAIL req_timeout: addr %h got no mem_resp required one within 60 cycles", addr);
      mem_read = 1'b0; mem_write = 1'b0; pmem_resp = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    //            wr    rd    addr          wdata          be     chk   rdata         lat fl fill_addr    wb wb_addr
    vecs[0]  = '{1'b0, 1'b1, 32'h0000_0040, 32'h0,         4'h0, 1'b1, 32'hA500_0040, 5, 1, 32'h0000_0040, 0, 32'h0};
    vecs[1]  = '{1'b0, 1'b1, 32'h0000_0040, 32'h0,         4'h0, 1'b1, 32'hA500_0040, 2, 0, 32'h0,         0, 32'h0};
    vecs[2]  = '{1'b1, 1'b0, 32'h0000_0044, 32'hDEAD_BEEF, 4'h3, 1'b0, 32'h0,         2, 0, 32'h0,         0, 32'h0};
    vecs[3]  = '{1'b0, 1'b1, 32'h0000_0044, 32'h0,         4'h0, 1'b1, 32'hA500_BEEF, 2, 0, 32'h0,         0, 32'h0};
    vecs[4]  = '{1'b1, 1'b0, 32'h0000_0148, 32'h1234_5678, 4'hF, 1'b0, 32'h0,         5, 1, 32'h0000_0140, 0, 32'h0};
    vecs[5]  = '{1'b0, 1'b1, 32'h0000_0240, 32'h0,         4'h0, 1'b1, 32'hA500_0240, 5, 1, 32'h0000_0240, 0, 32'h0};
    vecs[6]  = '{1'b0, 1'b1, 32'h0000_034C, 32'h0,         4'h0, 1'b1, 32'hA500_034C, 5, 1, 32'h0000_0340, 0, 32'h0};
    vecs[7]  = '{1'b0, 1'b1, 32'h0000_0040, 32'h0,         4'h0, 1'b1, 32'hA500_0040, 2, 0, 32'h0,         0, 32'h0};
    vecs[8]  = '{1'b0, 1'b1, 32'h0000_0440, 32'h0,         4'h0, 1'b1, 32'hA500_0440, 8, 1, 32'h0000_0440, 1, 32'h0000_0140};
    vecs[9]  = '{1'b0, 1'b1, 32'h0000_0148, 32'h0,         4'h0, 1'b1, 32'h1234_5678, 5, 1, 32'h0000_0140, 0, 32'h0};
    vecs[10] = '{1'b0, 1'b1, 32'h0000_0244, 32'h0,         4'h0, 1'b1, 32'hA500_0244, 5, 1, 32'h0000_0240, 0, 32'h0};
    vecs[11] = '{1'b1, 1'b1, 32'h0000_004C, 32'hCAFE_F00D, 4'hF, 1'b0, 32'h0,         2, 0, 32'h0,         0, 32'h0};
    vecs[12] = '{1'b0, 1'b1, 32'h0000_004C, 32'h0,         4'h0, 1'b1, 32'hCAFE_F00D, 2, 0, 32'h0,         0, 32'h0};
    vecs[13] = '{1'b1, 1'b0, 32'h0000_0244, 32'hFFFF_FFFF, 4'h0, 1'b0, 32'h0,         2, 0, 32'h0,         0, 32'h0};
    vecs[14] = '{1'b0, 1'b1, 32'h0000_0540, 32'h0,         4'h0, 1'b1, 32'hA500_0540, 5, 1, 32'h0000_0540, 0, 32'h0};
    vecs[15] = '{1'b0, 1'b1, 32'h0000_0440, 32'h0,         4'h0, 1'b1, 32'hA500_0440, 2, 0, 32'h0,         0, 32'h0};
    vecs[16] = '{1'b0, 1'b1, 32'h0000_0540, 32'h0,         4'h0, 1'b1, 32'hA500_0540, 2, 0, 32'h0,         0, 32'h0};
    vecs[17] = '{1'b0, 1'b1, 32'h0000_0640, 32'h0,         4'h0, 1'b1, 32'hA500_0640, 5, 1, 32'h0000_0640, 0, 32'h0};

    rst = 1'b1; mem_address = 32'd0; mem_wdata = 32'd0; mem_read = 1'b0; mem_write = 1'b0;
    mem_byte_enable = 4'd0; pmem_rdata = '0; pmem_resp = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check32("rst_mem_resp",   {31'd0, mem_resp}, 32'd0);
    check32("rst_mem_rdata",  mem_rdata, 32'd0);
    check32("rst_pmem_read",  {31'd0, pmem_read}, 32'd0);
    check32("rst_pmem_write", {31'd0, pmem_write}, 32'd0);
    check32("rst_pmem_addr",  pmem_address, 32'd0);
    check32("rst_pmem_wdata", {31'd0, pmem_wdata == '0}, 32'd1);
    rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      do_req(vecs[i].wr, vecs[i].rd, vecs[i].addr, vecs[i].wdata, vecs[i].be);
      check32($sformatf("v%0d_latency", i), 32'(r_lat), 32'(vecs[i].lat));
      if (vecs[i].chk) check32($sformatf("v%0d_rdata", i), r_rdata, vecs[i].rdata);
      check32($sformatf("v%0d_fills", i), 32'(r_fills), 32'(vecs[i].fills));
      if (vecs[i].fills > 0) check32($sformatf("v%0d_fill_addr", i), r_fill_addr, vecs[i].fill_addr);
      check32($sformatf("v%0d_writebacks", i), 32'(r_wbs), 32'(vecs[i].wbs));
      if (vecs[i].wbs > 0) check32($sformatf("v%0d_wb_addr", i), r_wb_addr, vecs[i].wb_addr);
      if (i == 8) begin
        check32("v8_wb_word2", r_wb_data[95:64], 32'h1234_5678);
        check32("v8_wb_word0", r_wb_data[31:0], 32'hA500_0140);
      end
    end

`ifdef CACHE_NWAY_PERF_EN
    check32("perf_hits",       perf_hits,       32'd9);
    check32("perf_misses",     perf_misses,     32'd9);
    check32("perf_writebacks", perf_writebacks, 32'd1);
`endif

    // Reset while a fill is outstanding, then confirm the cache forgot everything.
    @(negedge clk);
    mem_read = 1'b1; mem_write = 1'b0; mem_address = 32'h0000_0060; mem_byte_enable = 4'd0;
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      seen = pmem_read;
    end
    check32("midfill_pmem_read_seen", {31'd0, seen}, 32'd1);
    rst = 1'b1; mem_read = 1'b0;
    @(negedge clk);
    check32("midfill_rst_pmem_read",  {31'd0, pmem_read}, 32'd0);
    check32("midfill_rst_pmem_write", {31'd0, pmem_write}, 32'd0);
    check32("midfill_rst_mem_resp",   {31'd0, mem_resp}, 32'd0);
`ifdef CACHE_NWAY_PERF_EN
    check32("perf_rst_hits", perf_hits, 32'd0);
`endif
    rst = 1'b0;

    do_req(1'b0, 1'b1, 32'h0000_0060, 32'd0, 4'd0);
    check32("after_rst_060_latency", 32'(r_lat), 32'd5);
    check32("after_rst_060_fill", r_fill_addr, 32'h0000_0060);
    check32("after_rst_060_rdata", r_rdata, 32'hA500_0060);
    do_req(1'b0, 1'b1, 32'h0000_0044, 32'd0, 4'd0);
    check32("after_rst_044_latency", 32'(r_lat), 32'd5);
    check32("after_rst_044_wbs", 32'(r_wbs), 32'd0);
    check32("after_rst_044_rdata", r_rdata, 32'hA500_0044);
    do_req(1'b0, 1'b1, 32'h0000_0440, 32'd0, 4'd0);
    check32("after_rst_440_latency", 32'(r_lat), 32'd5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
